// File: rtl/platform_utils_ccip_active_tracker.sv
// Outstanding-request tracker for both CCI-P channels with saturating counters, credit flags
// and sticky error bits. Define PLATFORM_UTILS_ACTIVE_PEAK_EN to build the high-water marks.

package ccip_if_pkg;

    typedef logic [1:0]  t_ccip_vc;
    typedef logic [1:0]  t_ccip_clLen;
    typedef logic [1:0]  t_ccip_clNum;
    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h6
    } t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_ccip_clNum  cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

endpackage

module platform_utils_ccip_active_tracker
    import ccip_if_pkg::*;
#(
    parameter int unsigned C0_CNT_WIDTH = 10,
    parameter int unsigned C1_CNT_WIDTH = 10,
    parameter int unsigned REG_FLAGS    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  t_if_ccip_c0_Tx          c0Tx,
    input  t_if_ccip_c0_Rx          c0Rx,
    input  t_if_ccip_c1_Tx          c1Tx,
    input  t_if_ccip_c1_Rx          c1Rx,

    input  logic [C0_CNT_WIDTH-1:0] c0_thresh,
    input  logic [C1_CNT_WIDTH-1:0] c1_thresh,

    output logic [C0_CNT_WIDTH-1:0] c0_cnt,
    output logic [C1_CNT_WIDTH-1:0] c1_cnt,
    output logic                    c0_almost_full,
    output logic                    c1_almost_full,
    output logic [1:0]              err_underflow,
    output logic [1:0]              err_overflow,
    output logic [C0_CNT_WIDTH-1:0] c0_peak,
    output logic [C1_CNT_WIDTH-1:0] c1_peak
);

    // Two headroom bits: one for the sign, one so +4 from full scale cannot wrap.
    localparam int unsigned C0_SUM_W = C0_CNT_WIDTH + 2;
    localparam int unsigned C1_SUM_W = C1_CNT_WIDTH + 2;

    logic [2:0]                c0_incr;
    logic                      c0_decr;
    logic                      c1_incr;
    logic [2:0]                c1_decr;

    logic signed [3:0]         c0_delta_d, c0_delta_q;
    logic signed [3:0]         c1_delta_d, c1_delta_q;

    logic signed [C0_SUM_W-1:0] c0_sum;
    logic signed [C1_SUM_W-1:0] c1_sum;
    logic                      c0_under, c0_over;
    logic                      c1_under, c1_over;

    logic [C0_CNT_WIDTH-1:0]   c0_cnt_d, c0_cnt_q;
    logic [C1_CNT_WIDTH-1:0]   c1_cnt_d, c1_cnt_q;
    logic [1:0]                err_underflow_d, err_underflow_q;
    logic [1:0]                err_overflow_d, err_overflow_q;

    // Header fields other than the ones decoded below are irrelevant to the count.
    logic unused_in;
    assign unused_in = ^{c0Tx, c0Rx, c1Tx, c1Rx};

    // Stage 1: per-channel event decode into a signed delta.
    always_comb begin
        c0_incr = 3'd0;
        if (c0Tx.valid) begin
            c0_incr = 3'd1 + {1'b0, c0Tx.hdr.cl_len};
        end
        c0_decr = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);

        c1_incr = c1Tx.valid;
        c1_decr = 3'd0;
        if (c1Rx.rspValid) begin
            // A packed write response retires cl_num+1 requests at once.
            if ((c1Rx.hdr.resp_type == eRSP_WRLINE) && c1Rx.hdr.format) begin
                c1_decr = 3'd1 + {1'b0, c1Rx.hdr.cl_num};
            end else begin
                c1_decr = 3'd1;
            end
        end

        c0_delta_d = $signed({1'b0, c0_incr}) - $signed({3'b000, c0_decr});
        c1_delta_d = $signed({3'b000, c1_incr}) - $signed({1'b0, c1_decr});
    end

    // Stage 2: apply delta with saturation.
    always_comb begin
        c0_sum = $signed({2'b00, c0_cnt_q})
               + $signed({{(C0_SUM_W-4){c0_delta_q[3]}}, c0_delta_q});
        c1_sum = $signed({2'b00, c1_cnt_q})
               + $signed({{(C1_SUM_W-4){c1_delta_q[3]}}, c1_delta_q});

        c0_under = c0_sum[C0_SUM_W-1];
        c0_over  = !c0_sum[C0_SUM_W-1] && c0_sum[C0_SUM_W-2];
        c1_under = c1_sum[C1_SUM_W-1];
        c1_over  = !c1_sum[C1_SUM_W-1] && c1_sum[C1_SUM_W-2];

        if (c0_under) begin
            c0_cnt_d = '0;
        end else if (c0_over) begin
            c0_cnt_d = '1;
        end else begin
            c0_cnt_d = c0_sum[C0_CNT_WIDTH-1:0];
        end

        if (c1_under) begin
            c1_cnt_d = '0;
        end else if (c1_over) begin
            c1_cnt_d = '1;
        end else begin
            c1_cnt_d = c1_sum[C1_CNT_WIDTH-1:0];
        end

        err_underflow_d = err_underflow_q | {c1_under, c0_under};
        err_overflow_d  = err_overflow_q  | {c1_over,  c0_over};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c0_delta_q      <= '0;
            c1_delta_q      <= '0;
            c0_cnt_q        <= '0;
            c1_cnt_q        <= '0;
            err_underflow_q <= '0;
            err_overflow_q  <= '0;
        end else begin
            c0_delta_q      <= c0_delta_d;
            c1_delta_q      <= c1_delta_d;
            c0_cnt_q        <= c0_cnt_d;
            c1_cnt_q        <= c1_cnt_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

    assign c0_cnt        = c0_cnt_q;
    assign c1_cnt        = c1_cnt_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;

    if (REG_FLAGS != 0) begin : g_reg_flags
        logic c0_af_q, c1_af_q;

        // Evaluated from next-count so the flag lands on the same edge as the count.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                c0_af_q <= 1'b0;
                c1_af_q <= 1'b0;
            end else begin
                c0_af_q <= (c0_cnt_d >= c0_thresh);
                c1_af_q <= (c1_cnt_d >= c1_thresh);
            end
        end

        assign c0_almost_full = c0_af_q;
        assign c1_almost_full = c1_af_q;
    end else begin : g_comb_flags
        assign c0_almost_full = (c0_cnt_q >= c0_thresh);
        assign c1_almost_full = (c1_cnt_q >= c1_thresh);
    end

`ifdef PLATFORM_UTILS_ACTIVE_PEAK_EN
    logic [C0_CNT_WIDTH-1:0] c0_peak_q;
    logic [C1_CNT_WIDTH-1:0] c1_peak_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c0_peak_q <= '0;
            c1_peak_q <= '0;
        end else begin
            c0_peak_q <= (c0_cnt_d > c0_peak_q) ? c0_cnt_d : c0_peak_q;
            c1_peak_q <= (c1_cnt_d > c1_peak_q) ? c1_cnt_d : c1_peak_q;
        end
    end

    assign c0_peak = c0_peak_q;
    assign c1_peak = c1_peak_q;
`else
    assign c0_peak = '0;
    assign c1_peak = '0;
`endif

endmodule

// File: tb/tb_platform_utils_ccip_active_tracker.sv
// Scoreboard bench: two tracker instances (default build, and 3-bit counters with
// combinational flags) share stimulus; a reference counter model feeds an expectation queue.

module tb_platform_utils_ccip_active_tracker;
    import ccip_if_pkg::*;

    localparam int unsigned WA = 10;
    localparam int unsigned WB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    t_if_ccip_c0_Tx c0Tx;
    t_if_ccip_c0_Rx c0Rx;
    t_if_ccip_c1_Tx c1Tx;
    t_if_ccip_c1_Rx c1Rx;

    logic [WA-1:0] thr0_a, thr1_a, c0_cnt_a, c1_cnt_a, c0_peak_a, c1_peak_a;
    logic [WB-1:0] thr0_b, thr1_b, c0_cnt_b, c1_cnt_b, c0_peak_b, c1_peak_b;
    logic          c0_af_a, c1_af_a, c0_af_b, c1_af_b;
    logic [1:0]    uf_a, of_a, uf_b, of_b;

    platform_utils_ccip_active_tracker #(
        .C0_CNT_WIDTH (WA),
        .C1_CNT_WIDTH (WA),
        .REG_FLAGS    (1)
    ) dut_a (
        .clk            (clk),
        .reset_n        (reset_n),
        .c0Tx           (c0Tx),
        .c0Rx           (c0Rx),
        .c1Tx           (c1Tx),
        .c1Rx           (c1Rx),
        .c0_thresh      (thr0_a),
        .c1_thresh      (thr1_a),
        .c0_cnt         (c0_cnt_a),
        .c1_cnt         (c1_cnt_a),
        .c0_almost_full (c0_af_a),
        .c1_almost_full (c1_af_a),
        .err_underflow  (uf_a),
        .err_overflow   (of_a),
        .c0_peak        (c0_peak_a),
        .c1_peak        (c1_peak_a)
    );

    platform_utils_ccip_active_tracker #(
        .C0_CNT_WIDTH (WB),
        .C1_CNT_WIDTH (WB),
        .REG_FLAGS    (0)
    ) dut_b (
        .clk            (clk),
        .reset_n        (reset_n),
        .c0Tx           (c0Tx),
        .c0Rx           (c0Rx),
        .c1Tx           (c1Tx),
        .c1Rx           (c1Rx),
        .c0_thresh      (thr0_b),
        .c1_thresh      (thr1_b),
        .c0_cnt         (c0_cnt_b),
        .c1_cnt         (c1_cnt_b),
        .c0_almost_full (c0_af_b),
        .c1_almost_full (c1_af_b),
        .err_underflow  (uf_b),
        .err_overflow   (of_b),
        .c0_peak        (c0_peak_b),
        .c1_peak        (c1_peak_b)
    );

    typedef struct {
        int         c0;
        int         c1;
        logic [1:0] uf;
        logic [1:0] of;
        int         p0;
        int         p1;
    } exp_t;

    exp_t exp_q[$];
    exp_t ma, mb, zero_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    function automatic exp_t advance(input exp_t s, input int w, input int inc0, input int dec0,
                                     input int inc1, input int dec1);
        int mx;
        int n;
        mx = (1 << w) - 1;
        n = s.c0 + inc0 - dec0;
        if (n < 0) begin
            n = 0;
            s.uf[0] = 1'b1;
        end else if (n > mx) begin
            n = mx;
            s.of[0] = 1'b1;
        end
        s.c0 = n;
        n = s.c1 + inc1 - dec1;
        if (n < 0) begin
            n = 0;
            s.uf[1] = 1'b1;
        end else if (n > mx) begin
            n = mx;
            s.of[1] = 1'b1;
        end
        s.c1 = n;
`ifdef PLATFORM_UTILS_ACTIVE_PEAK_EN
        if (s.c0 > s.p0) s.p0 = s.c0;
        if (s.c1 > s.p1) s.p1 = s.c1;
`endif
        return s;
    endfunction

    task automatic compare_pop();
        exp_t ea, eb;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        check_value("a.c0_cnt", 32'(c0_cnt_a), ea.c0);
        check_value("a.c1_cnt", 32'(c1_cnt_a), ea.c1);
        check_value("a.c0_af", 32'(c0_af_a), 32'(ea.c0 >= int'(thr0_a)));
        check_value("a.c1_af", 32'(c1_af_a), 32'(ea.c1 >= int'(thr1_a)));
        check_value("a.err_uf", 32'(uf_a), 32'(ea.uf));
        check_value("a.err_of", 32'(of_a), 32'(ea.of));
        check_value("a.c0_peak", 32'(c0_peak_a), ea.p0);
        check_value("a.c1_peak", 32'(c1_peak_a), ea.p1);
        check_value("b.c0_cnt", 32'(c0_cnt_b), eb.c0);
        check_value("b.c1_cnt", 32'(c1_cnt_b), eb.c1);
        check_value("b.c0_af", 32'(c0_af_b), 32'(eb.c0 >= int'(thr0_b)));
        check_value("b.c1_af", 32'(c1_af_b), 32'(eb.c1 >= int'(thr1_b)));
        check_value("b.err_uf", 32'(uf_b), 32'(eb.uf));
        check_value("b.err_of", 32'(of_b), 32'(eb.of));
        check_value("b.c0_peak", 32'(c0_peak_b), eb.p0);
        check_value("b.c1_peak", 32'(c1_peak_b), eb.p1);
    endtask

    task automatic drive(input bit v0, input logic [1:0] cl, input bit r0v, input bit r0umsg,
                         input bit v1, input bit r1v, input bit r1fence, input bit fmt,
                         input logic [1:0] cln);
        c0Tx = '0;
        c0Tx.valid = v0;
        c0Tx.hdr.cl_len = cl;
        c0Tx.hdr.mdata = 16'($urandom);
        c0Rx = '0;
        c0Rx.rspValid = r0v;
        if (r0umsg) c0Rx.hdr.resp_type = eRSP_UMSG;
        else        c0Rx.hdr.resp_type = eRSP_RDLINE;
        c0Rx.hdr.cl_num = 2'($urandom);
        c1Tx = '0;
        c1Tx.valid = v1;
        if ($urandom_range(0, 3) == 0) c1Tx.hdr.req_type = eREQ_WRFENCE;
        else                           c1Tx.hdr.req_type = eREQ_WRLINE_I;
        c1Rx = '0;
        c1Rx.rspValid = r1v;
        if (r1fence) c1Rx.hdr.resp_type = eRSP_WRFENCE;
        else         c1Rx.hdr.resp_type = eRSP_WRLINE;
        c1Rx.hdr.format = fmt;
        c1Rx.hdr.cl_num = cln;
    endtask

    // One clock: check the entry whose result is now visible, then drive and predict.
    task automatic step(input bit v0, input logic [1:0] cl, input bit r0v, input bit r0umsg,
                        input bit v1, input bit r1v, input bit r1fence, input bit fmt,
                        input logic [1:0] cln);
        int inc0, dec0, inc1, dec1;
        @(negedge clk);
        if (exp_q.size() >= 4) compare_pop();
        reset_n = 1'b1;
        drive(v0, cl, r0v, r0umsg, v1, r1v, r1fence, fmt, cln);
        inc0 = v0 ? 1 + int'(cl) : 0;
        dec0 = (r0v && !r0umsg) ? 1 : 0;
        inc1 = v1 ? 1 : 0;
        dec1 = r1v ? ((!r1fence && fmt) ? 1 + int'(cln) : 1) : 0;
        ma = advance(ma, WA, inc0, dec0, inc1, dec1);
        mb = advance(mb, WB, inc0, dec0, inc1, dec1);
        exp_q.push_back(ma);
        exp_q.push_back(mb);
    endtask

    // Reset at the coming edge also discards the update still in the pipeline.
    task automatic pulse_reset();
        @(negedge clk);
        if (exp_q.size() >= 4) compare_pop();
        if (exp_q.size() >= 2) begin
            exp_q[exp_q.size()-2] = zero_e;
            exp_q[exp_q.size()-1] = zero_e;
        end
        reset_n = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        ma = zero_e;
        mb = zero_e;
        exp_q.push_back(zero_e);
        exp_q.push_back(zero_e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic c0_req(input logic [1:0] cl);
        step(1, cl, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic c0_rsp();
        step(0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic c1_req();
        step(0, 2'd0, 0, 0, 1, 0, 0, 0, 2'd0);
    endtask

    task automatic c1_rsp(input bit fmt, input logic [1:0] cln);
        step(0, 2'd0, 0, 0, 0, 1, 0, fmt, cln);
    endtask

    initial begin
        zero_e = '{c0: 0, c1: 0, uf: 2'b00, of: 2'b00, p0: 0, p1: 0};
        ma = zero_e;
        mb = zero_e;
        reset_n = 1'b0;
        drive(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
        thr0_a = WA'(8);
        thr1_a = WA'(5);
        thr0_b = WB'(4);
        thr1_b = WB'(2);
        pulse_reset();
        pulse_reset();

        // Four-line read, then four single-line responses.
        c0_req(2'd3);
        idle(3);
        repeat (4) c0_rsp();
        idle(2);

        // From cnt=5, a 2-line request and a response in the same cycle nets +1.
        c0_req(2'd3);
        c0_req(2'd0);
        idle(1);
        step(1, 2'd1, 1, 0, 0, 0, 0, 0, 2'd0);
        idle(2);
        repeat (6) c0_rsp();
        // UMSG responses do not retire read lines.
        step(0, 2'd0, 1, 1, 0, 0, 0, 0, 2'd0);
        idle(2);

        // Packed c1 write response, then the unpacked variant.
        repeat (4) c1_req();
        idle(1);
        c1_rsp(1, 2'd3);
        idle(2);
        repeat (4) c1_req();
        c1_rsp(0, 2'd3);
        idle(1);
        repeat (3) c1_rsp(0, 2'd0);
        idle(2);

        // Underflow: response with nothing outstanding; error stays set.
        c0_rsp();
        idle(3);

        // Overflow of the 3-bit instance on both channels, then drain past zero.
        pulse_reset();
        repeat (3) c0_req(2'd1);
        c0_req(2'd3);
        idle(2);
        repeat (9) c1_req();
        idle(2);
        repeat (9) c1_rsp(0, 2'd0);
        repeat (10) c0_rsp();
        idle(2);

        // Flag edges around a threshold, threshold changes, and threshold zero.
        pulse_reset();
        thr1_a = WA'(2);
        c1_req();
        c1_req();
        idle(1);
        c1_rsp(0, 2'd0);
        idle(1);
        thr1_a = WA'(1);
        thr1_b = WB'(1);
        idle(1);
        thr0_a = '0;
        thr0_b = '0;
        idle(2);
        c1_rsp(1, 2'd0);
        idle(1);
        thr0_a = WA'(8);
        thr0_b = WB'(4);
        thr1_a = WA'(5);
        thr1_b = WB'(2);
        idle(2);

        // Reset with work still in the pipeline.
        c0_req(2'd3);
        c0_req(2'd3);
        idle(2);
        repeat (5) c0_rsp();
        idle(2);
        step(1, 2'd3, 0, 0, 1, 0, 0, 0, 2'd0);
        pulse_reset();
        idle(4);

        // Randomised mix with occasional threshold changes.
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) begin
                thr0_a = WA'($urandom_range(0, 12));
                thr1_a = WA'($urandom_range(0, 12));
                thr0_b = WB'($urandom_range(0, 7));
                thr1_b = WB'($urandom_range(0, 7));
            end
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
